// File: rtl/mem_arb.sv
// Byte-serial arbiter for the shared RAM port: IF fetches vs MEM accesses, little-endian assembly.
// Optional IF anti-starvation forcing is built only when ARB_STARVE_EN is defined.
module mem_arb #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_a,
    input  logic              if_clr,
    output logic [31:0]       if_n,
    output logic              if_ok,
    input  logic              mm_req,
    input  logic              mm_wr,
    input  logic [1:0]        mm_cu,
    input  logic [ADDR_W-1:0] mm_a,
    input  logic [31:0]       mm_n_i,
    output logic [31:0]       mm_n_o,
    output logic              mm_ok,
    output logic              mm_stl,
    input  logic [7:0]        rom_rn,
    output logic [7:0]        rom_wn,
    output logic [ADDR_W-1:0] rom_a,
    output logic              rom_wr,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_rom_a;
    logic [31:0]       r_buf;
    logic [31:0]       r_wdata;
    logic [2:0]        r_len;
    logic [2:0]        r_cnt;
    logic              r_is_if;

    logic              w_idle;
    logic              w_if_pend;
    logic              w_force_if;
    logic              w_gnt_if;
    logic              w_gnt_mm;
    logic [2:0]        w_mm_len;
    logic              w_abort;
    logic              w_rd_done;
    logic [2:0]        w_cap;

    assign w_idle    = (r_state == S_IDLE);
    assign w_if_pend = if_req & ~if_clr;
    assign w_mm_len  = (mm_cu == 2'b00) ? 3'd1 : (mm_cu == 2'b01) ? 3'd2 : 3'd4;

`ifdef ARB_STARVE_EN
    localparam int SC_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    logic [SC_W-1:0] r_starve;

    assign w_force_if = (r_starve == SC_W'(STARVE_LIM)) & mm_req & w_if_pend;

    // Counts MEM grants that overtook a waiting fetch; saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_gnt_if || !if_req) begin
            r_starve <= '0;
        end else if (w_gnt_mm && w_if_pend && (r_starve != SC_W'(STARVE_LIM))) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    assign w_gnt_if  = w_idle & w_if_pend & (~mm_req | w_force_if);
    assign w_gnt_mm  = w_idle & mm_req & ~w_force_if;
    assign w_abort   = (r_state == S_RD) & r_is_if & if_clr;
    assign w_rd_done = (r_state == S_RD) & (r_cnt == r_len + 3'd1);
    assign w_cap     = r_cnt - 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_if)      w_next = S_RD;
                else if (w_gnt_mm) w_next = mm_wr ? S_WR : S_RD;
            end
            S_RD: if (w_abort || w_rd_done) w_next = S_IDLE;
            S_WR: if (r_cnt == r_len)       w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (r_state != S_IDLE);
        rom_a  = r_rom_a;
        rom_wr = (r_state == S_WR) && (r_cnt < r_len);
        rom_wn = rom_wr ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'h00;
        if_ok  = w_rd_done & r_is_if & ~if_clr;
        mm_ok  = (w_rd_done & ~r_is_if) | ((r_state == S_WR) && (r_cnt == r_len));
        if_n   = if_ok ? r_buf : 32'h0;
        mm_n_o = (w_rd_done & ~r_is_if) ? r_buf : 32'h0;
        mm_stl = mm_req & ~mm_ok;
    end

    // Request fields are frozen at grant; rom_a holds its last issued address while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rom_a <= '0;
            r_buf   <= '0;
            r_wdata <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_is_if <= 1'b0;
        end else if (w_idle) begin
            if (w_gnt_if || w_gnt_mm) begin
                r_is_if <= w_gnt_if;
                r_len   <= w_gnt_if ? 3'd4 : w_mm_len;
                r_rom_a <= w_gnt_if ? if_a : mm_a;
                r_wdata <= mm_n_i;
                r_buf   <= '0;
                r_cnt   <= '0;
            end
        end else begin
            r_cnt <= (w_next == S_IDLE) ? 3'd0 : r_cnt + 3'd1;
            if ((r_cnt + 3'd1) < r_len)
                r_rom_a <= r_rom_a + 1'b1;
            if ((r_state == S_RD) && (r_cnt != 3'd0) && (r_cnt <= r_len))
                r_buf[{w_cap[1:0], 3'b000} +: 8] <= rom_rn;
        end
    end

endmodule
